// File: rtl/ac_unit.sv
// Accumulator/E-link execution unit: one operation every two cycles (IDLE -> EXEC),
// result written to AC on leaving EXEC, E flip-flop updates requested from downstream.
module ac_unit #(
    parameter int WIDTH    = 16,
    parameter int IN_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                op_valid,
    input  logic [3:0]          op_code,
    input  logic [WIDTH-1:0]    dr_data,
    input  logic [IN_WIDTH-1:0] inpr_data,
    input  logic                e_outdata,
    output logic                e_indata,
    output logic                ff_en,
    output logic                e_clr,
    output logic [WIDTH-1:0]    ac_data,
    output logic                busy,
    output logic                done,
    output logic                ac_zero,
    output logic                ac_neg
);

    typedef enum logic {IDLE, EXEC} state_t;

    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_ADD = 4'd2;
    localparam logic [3:0] OP_LDA = 4'd3;
    localparam logic [3:0] OP_CLA = 4'd4;
    localparam logic [3:0] OP_CMA = 4'd5;
    localparam logic [3:0] OP_INC = 4'd6;
    localparam logic [3:0] OP_CIR = 4'd7;
    localparam logic [3:0] OP_CIL = 4'd8;
    localparam logic [3:0] OP_CLE = 4'd9;
    localparam logic [3:0] OP_CME = 4'd10;
    localparam logic [3:0] OP_INP = 4'd11;

    state_t             state, state_next;
    logic [3:0]         op_p0;
    logic [WIDTH-1:0]   dr_p0;
    logic [WIDTH-1:0]   ac;
    logic [WIDTH-1:0]   ac_result;
    logic [WIDTH:0]     sum;
    logic               e_result;
    logic               e_write;
    logic               e_clear;

    function automatic logic [WIDTH:0] add_with_carry(input logic [WIDTH-1:0] a,
                                                      input logic [WIDTH-1:0] b);
        return {1'b0, a} + {1'b0, b};
    endfunction

    function automatic logic [WIDTH-1:0] merge_char(input logic [WIDTH-1:0]    a,
                                                    input logic [IN_WIDTH-1:0] ch);
        logic [WIDTH-1:0] mask;
        mask = WIDTH'({IN_WIDTH{1'b1}});
        return (a & ~mask) | WIDTH'(ch);
    endfunction

    // p0: operands frozen on acceptance so input changes during EXEC are ignored
    always_ff @(posedge clk) begin
        if (state == IDLE && op_valid) begin
            op_p0 <= op_code;
            dr_p0 <= dr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (op_valid) state_next = EXEC;
            EXEC:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign sum = add_with_carry(ac, dr_p0);

    // EXEC: result from captured operands, live AC and live downstream E
    always_comb begin
        ac_result = ac;
        e_result  = 1'b0;
        e_write   = 1'b0;
        e_clear   = 1'b0;
        case (op_p0)
            OP_AND: ac_result = ac & dr_p0;
            OP_ADD: begin
                ac_result = sum[WIDTH-1:0];
                e_result  = sum[WIDTH];
                e_write   = 1'b1;
            end
            OP_LDA: ac_result = dr_p0;
            OP_CLA: ac_result = '0;
            OP_CMA: ac_result = ~ac;
            OP_INC: ac_result = ac + {{(WIDTH-1){1'b0}}, 1'b1};
            OP_CIR: begin
                ac_result = {e_outdata, ac[WIDTH-1:1]};
                e_result  = ac[0];
                e_write   = 1'b1;
            end
            OP_CIL: begin
                ac_result = {ac[WIDTH-2:0], e_outdata};
                e_result  = ac[WIDTH-1];
                e_write   = 1'b1;
            end
            OP_CLE: begin
                e_write = 1'b1;
                e_clear = 1'b1;
            end
            OP_CME: begin
                e_result = ~e_outdata;
                e_write  = 1'b1;
            end
            OP_INP: ac_result = merge_char(ac, inpr_data);
            default: ;
        endcase
    end

    // Reset drives a clear into the downstream E flip-flop so both sides start in step
    always_comb begin
        ff_en    = 1'b0;
        e_clr    = 1'b0;
        e_indata = 1'b0;
        if (reset) begin
            ff_en = 1'b1;
            e_clr = 1'b1;
        end else if (state == EXEC && e_write) begin
            ff_en    = 1'b1;
            e_clr    = e_clear;
            e_indata = e_clear ? 1'b0 : e_result;
        end
    end

    // p1: AC write-back and completion pulse on leaving EXEC
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ac   <= '0;
            done <= 1'b0;
        end else begin
            done <= (state == EXEC);
            if (state == EXEC) begin
                ac <= ac_result;
            end
        end
    end

    assign busy    = (state == EXEC);
    assign ac_data = ac;
    assign ac_zero = (ac == '0);
    assign ac_neg  = ac[WIDTH-1];

endmodule

// File: tb/tb_ac_unit.sv
// Bench for ac_unit: arithmetic reference model checked every cycle, plus directed
// operation sequences with literal expectations.
module tb_ac_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        op_valid = 1'b0;
    logic [3:0]  op_code = 4'h0;
    logic [15:0] dr_data = 16'h0000;
    logic [7:0]  inpr_data = 8'h00;
    logic        e_outdata;
    logic        e_indata, ff_en, e_clr, busy, done, ac_zero, ac_neg;
    logic [15:0] ac_data;
    logic        e_ff;

    int tests = 0;
    int fails = 0;
    bit model_on = 1'b0;

    always #5 clk = ~clk;

    ac_unit #(.WIDTH(16), .IN_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
        .dr_data(dr_data), .inpr_data(inpr_data), .e_outdata(e_outdata),
        .e_indata(e_indata), .ff_en(ff_en), .e_clr(e_clr), .ac_data(ac_data),
        .busy(busy), .done(done), .ac_zero(ac_zero), .ac_neg(ac_neg)
    );

    // downstream E flip-flop
    always @(posedge clk or posedge reset) begin
        if (reset) e_ff <= 1'b0;
        else if (ff_en) e_ff <= e_clr ? 1'b0 : e_indata;
    end
    assign e_outdata = e_ff;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Instruction semantics in plain integer arithmetic on a 16-bit AC and 1-bit E.
    task automatic calc(input int op, input int ac, input int dr, input int e, input int inp,
                        output int nac, output int ne, output int fe, output int ec);
        int s;
        nac = ac; ne = e; fe = 0; ec = 0;
        case (op)
            1:  nac = ac & dr;
            2:  begin s = ac + dr; nac = s % 65536; ne = (s >= 65536) ? 1 : 0; fe = 1; end
            3:  nac = dr;
            4:  nac = 0;
            5:  nac = 65535 - ac;
            6:  nac = (ac + 1) % 65536;
            7:  begin nac = ac / 2 + e * 32768; ne = ac % 2; fe = 1; end
            8:  begin nac = (ac * 2) % 65536 + e; ne = (ac >= 32768) ? 1 : 0; fe = 1; end
            9:  begin ne = 0; fe = 1; ec = 1; end
            10: begin ne = (e == 0) ? 1 : 0; fe = 1; end
            11: nac = ac - (ac % 256) + inp;
            default: ;
        endcase
    endtask

    int m_ac = 0, m_e = 0, m_busy = 0, m_done = 0, m_op = 0, m_dr = 0;

    always @(negedge clk) begin
        int nac, ne, fe, ec, ei;
        if (reset) begin
            m_ac = 0; m_e = 0; m_busy = 0; m_done = 0;
        end
        nac = m_ac; ne = m_e; fe = 0; ec = 0; ei = 0;
        if (reset) begin
            fe = 1; ec = 1;
        end else if (m_busy != 0) begin
            calc(m_op, m_ac, m_dr, m_e, int'(inpr_data), nac, ne, fe, ec);
            ei = (fe != 0 && ec == 0) ? ne : 0;
        end
        if (model_on) begin
            chk("m_ac", ac_data, m_ac);
            chk("m_zero", ac_zero, (m_ac == 0) ? 1 : 0);
            chk("m_neg", ac_neg, (m_ac >= 32768) ? 1 : 0);
            chk("m_busy", busy, m_busy);
            chk("m_done", done, m_done);
            chk("m_ff_en", ff_en, fe);
            chk("m_e_clr", e_clr, ec);
            chk("m_e_indata", e_indata, ei);
            chk("m_e", e_ff, m_e);
        end
        if (reset) begin
            m_ac = 0; m_e = 0; m_busy = 0; m_done = 0;
        end else begin
            m_done = m_busy;
            if (m_busy != 0) begin
                m_ac = nac; m_e = ne; m_busy = 0;
            end else if (op_valid) begin
                m_busy = 1; m_op = int'(op_code); m_dr = int'(dr_data);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic run_op(input logic [3:0] c, input logic [15:0] d, input logic [7:0] inp,
                          output logic fe, output logic ec, output logic ei, output logic dn);
        op_valid = 1'b1; op_code = c; dr_data = d; inpr_data = inp;
        tick();
        op_valid = 1'b0; op_code = 4'h0; dr_data = 16'hDEAD;
        fe = ff_en; ec = e_clr; ei = e_indata;
        tick();
        dn = done;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, tests %0d", tests);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic fe, ec, ei, dn, b1, b2, b3;
        logic [15:0] a_mid;
        #1 reset = 1'b1;
        model_on = 1'b1;
        repeat (2) tick();
        chk("rst_ff_en", ff_en, 1);
        chk("rst_e_clr", e_clr, 1);
        reset = 1'b0;
        #1;
        chk("rst_ac", ac_data, 16'h0000);
        chk("rst_zero", ac_zero, 1);
        chk("rst_neg", ac_neg, 0);

        // LDA FFFF then ADD 1 -> wrap with carry
        run_op(4'd3, 16'hFFFF, 8'h00, fe, ec, ei, dn);
        chk("lda_ac", ac_data, 16'hFFFF);
        chk("lda_neg", ac_neg, 1);
        run_op(4'd2, 16'h0001, 8'h00, fe, ec, ei, dn);
        chk("add_ff_en", fe, 1);
        chk("add_e_indata", ei, 1);
        chk("add_done", dn, 1);
        chk("add_ac", ac_data, 16'h0000);
        chk("add_zero", ac_zero, 1);

        // AC=8001, E cleared, rotate right then left
        run_op(4'd3, 16'h8001, 8'h00, fe, ec, ei, dn);
        run_op(4'd9, 16'h0000, 8'h00, fe, ec, ei, dn);
        run_op(4'd7, 16'h0000, 8'h00, fe, ec, ei, dn);
        chk("cir_ac", ac_data, 16'h4000);
        chk("cir_e_indata", ei, 1);
        run_op(4'd8, 16'h0000, 8'h00, fe, ec, ei, dn);
        chk("cil_ac", ac_data, 16'h8001);
        chk("cil_e_indata", ei, 0);

        // INC wrap leaves E alone; CLE clears it
        run_op(4'd3, 16'hFFFF, 8'h00, fe, ec, ei, dn);
        run_op(4'd6, 16'h0000, 8'h00, fe, ec, ei, dn);
        chk("inc_ac", ac_data, 16'h0000);
        chk("inc_ff_en", fe, 0);
        run_op(4'd9, 16'h0000, 8'h00, fe, ec, ei, dn);
        chk("cle_ff_en", fe, 1);
        chk("cle_e_clr", ec, 1);
        chk("cle_after_ff_en", ff_en, 0);

        // op_valid held high: LDA 1234 then CMA
        op_valid = 1'b1; op_code = 4'd3; dr_data = 16'h1234;
        tick(); b1 = busy; op_code = 4'd5;
        tick(); b2 = busy; a_mid = ac_data;
        tick(); b3 = busy; op_valid = 1'b0;
        tick();
        chk("hold_busy1", b1, 1);
        chk("hold_busy2", b2, 0);
        chk("hold_busy3", b3, 1);
        chk("hold_mid_ac", a_mid, 16'h1234);
        chk("hold_ac", ac_data, 16'hEDCB);
        chk("hold_done", done, 1);

        // INP and undefined code
        run_op(4'd3, 16'hAB00, 8'h00, fe, ec, ei, dn);
        run_op(4'd11, 16'h0000, 8'h5C, fe, ec, ei, dn);
        chk("inp_ac", ac_data, 16'hAB5C);
        run_op(4'hE, 16'h0000, 8'h00, fe, ec, ei, dn);
        chk("undef_ac", ac_data, 16'hAB5C);
        chk("undef_done", dn, 1);

        // AND, ADD without carry, CME
        run_op(4'd3, 16'hF0F0, 8'h00, fe, ec, ei, dn);
        run_op(4'd1, 16'h3C3C, 8'h00, fe, ec, ei, dn);
        chk("and_ac", ac_data, 16'h3030);
        run_op(4'd2, 16'h1111, 8'h00, fe, ec, ei, dn);
        chk("add2_ac", ac_data, 16'h4141);
        chk("add2_e_indata", ei, 0);
        run_op(4'd10, 16'h0000, 8'h00, fe, ec, ei, dn);
        chk("cme_e_indata", ei, 1);
        run_op(4'd4, 16'h0000, 8'h00, fe, ec, ei, dn);
        chk("cla_ac", ac_data, 16'h0000);

        // reset in the middle of an LDA
        run_op(4'd3, 16'h1111, 8'h00, fe, ec, ei, dn);
        op_valid = 1'b1; op_code = 4'd3; dr_data = 16'h5555;
        tick();
        op_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("mid_rst_ff_en", ff_en, 1);
        chk("mid_rst_e_clr", e_clr, 1);
        chk("mid_rst_e_indata", e_indata, 0);
        chk("mid_rst_ac", ac_data, 16'h0000);
        tick();
        reset = 1'b0;
        tick();
        chk("mid_rst_done1", done, 0);
        chk("mid_rst_ac2", ac_data, 16'h0000);
        tick();
        chk("mid_rst_done2", done, 0);
        run_op(4'd3, 16'h0042, 8'h00, fe, ec, ei, dn);
        chk("post_rst_ac", ac_data, 16'h0042);
        chk("post_rst_done", dn, 1);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
